// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: bus widths, state encoding, queue entry layout.
// No logic here; imported by fetch_queue and fetch_unit.
package fetch_unit_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    localparam logic [ISIZE-1:0] RESET_PC_DEF = 16'h0000;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DSIZE-1:0] inst;
        logic [ISIZE-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {inst, pc} entries with registered head (inst, pc, pc+1).
// Latency: a push into an empty queue is visible at the head on the next cycle.
// Backpressure: push ignored when full (unless popping); flush beats push and pop; head holds when empty.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fq_entry_t        push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output fq_entry_t        head_dat,
    output logic [ISIZE-1:0] head_npc
);

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          do_push, do_pop;
    fq_entry_t     head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        count_nxt  = flush ? '0 : count + CW'(do_push) - CW'(do_pop);
        rd_ptr_nxt = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
        // The new head is the word being written when the queue drains to exactly that slot.
        head_nxt   = (do_push && rd_ptr_nxt == wr_ptr) ? push_dat : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head_dat <= '0;
            head_npc <= ISIZE'(1);
        end else begin
            count <= count_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr_nxt;
                if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            end
            if (count_nxt != '0) begin
                head_dat <= head_nxt;
                head_npc <= head_nxt.pc + ISIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: held req/ack to imem, prefetch queue, valid/ready to decode; FETCH_STATS_EN adds counters.
// Latency: ack in cycle N -> inst_valid in N+1; redirect in N -> target address in N+1 (after any stale ack).
// Backpressure: no request while the queue is full; a redirect flushes the queue and drops in-flight data.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               DEPTH    = 2,
    parameter logic [ISIZE-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [ISIZE-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [DSIZE-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    input  logic             id_ready,
    output logic             inst_valid,
    output logic [DSIZE-1:0] inst,
    output logic [ISIZE-1:0] inst_pc,
    output logic [ISIZE-1:0] inst_npc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]      stat_fetch_cnt,
    output logic [15:0]      stat_discard_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("fetch_unit: DEPTH out of range");
    end

    fetch_state_t     state, state_nxt;
    logic [ISIZE-1:0] fetch_pc, fetch_pc_nxt, req_addr, req_addr_nxt;
    logic             active;
    logic [CW-1:0]    q_count;
    logic             q_full, q_empty, q_push, q_pop;
    logic             ack_hit, drop;
    fq_entry_t        head;

    // active keeps the request low until the first clock after reset release
    assign imem_req  = active && ((state == ST_DISCARD) || (q_count < CW'(DEPTH)));
    assign imem_addr = (state == ST_DISCARD) ? req_addr : fetch_pc;
    assign ack_hit   = imem_req && imem_ack;
    assign q_push    = ack_hit && (state == ST_FETCH) && !redirect_valid && !q_full;
    assign q_pop     = !q_empty && id_ready;
    assign drop      = ack_hit && !q_push;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        case (state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    if (imem_req && !imem_ack) begin
                        state_nxt    = ST_DISCARD;
                        req_addr_nxt = fetch_pc;
                    end
                end else if (ack_hit) begin
                    fetch_pc_nxt = fetch_pc + ISIZE'(1);
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) fetch_pc_nxt = redirect_pc;
                if (imem_ack)       state_nxt    = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
            active   <= 1'b1;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat ('{inst: imem_rdata, pc: fetch_pc}),
        .pop      (q_pop),
        .flush    (redirect_valid),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count),
        .head_dat (head),
        .head_npc (inst_npc)
    );

    assign inst_valid = !q_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetch_cnt   <= '0;
            stat_discard_cnt <= '0;
        end else begin
            if (q_push && stat_fetch_cnt != 16'hFFFF)   stat_fetch_cnt   <= stat_fetch_cnt + 16'd1;
            if (drop && stat_discard_cnt != 16'hFFFF)   stat_discard_cnt <= stat_discard_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit pipelined core. It drives the instruction memory with a held request/acknowledge handshake and buffers returned words in a small prefetch queue. It presents each instruction, with its PC and PC+1, to the decode stage over a valid/ready handshake. A branch redirect from the execute stage flushes the queue and restarts fetch at the target, discarding any response still in flight.

## Interface
- `DEPTH`, 2: prefetch queue entries, 2..8.
- `RESET_PC`, 16'h0000: first fetch address after reset.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  `ISIZE`  word address; stable while `imem_req` is high.
- `imem_ack`  in  1  response valid; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  `DSIZE`  instruction word; valid when `imem_ack` is high.
- `redirect_valid`  in  1  branch taken; one-cycle pulse.
- `redirect_pc`  in  `ISIZE`  branch target.
- `id_ready`  in  1  decode stage accepts this cycle.
- `inst_valid`  out  1  queue head valid.
- `inst`  out  `DSIZE`  head instruction.
- `inst_pc`  out  `ISIZE`  address of `inst`.
- `inst_npc`  out  `ISIZE`  `inst_pc` + 1, modulo 2^16; feeds the branch adder.

## Operation
- Reset values:
  - Queue is empty.
  - `inst_valid`, `imem_req` = 0; `inst`, `inst_pc` = 0; `inst_npc` = 1.
  - `imem_addr` = `RESET_PC`; `fetch_pc` = `RESET_PC`; state is FETCH.
- FSM has two states, FETCH and DISCARD.
- **FETCH**
  - `imem_req` = 1 when count < `DEPTH`; `imem_addr` = `fetch_pc`.
  - On `imem_ack`: push {`imem_rdata`, `fetch_pc`} and set `fetch_pc` += 1, wrapping 16'hFFFF to 16'h0000.
  - While a request is pending, count cannot grow, so the request never needs to be withdrawn.
- **Redirect in FETCH**
  - Flush the queue and set `fetch_pc` = `redirect_pc`.
  - If a request is pending and `imem_ack` = 0: latch the old address into `req_addr` and go to DISCARD.
  - If `imem_ack` = 1 in the same cycle: drop the returned word and stay in FETCH.
  - If no request is pending: stay in FETCH.
- **DISCARD**
  - `imem_req` = 1; `imem_addr` = `req_addr`, held stable.
  - On `imem_ack`: drop the data and go to FETCH; the next request uses `fetch_pc`.
  - A further redirect in DISCARD overwrites `fetch_pc` (last redirect wins); the state is unchanged.
- **Decode handshake**
  - Pop when `inst_valid` && `id_ready`.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Redirect has priority over both push and pop: the queue ends the cycle empty.
- **Queue boundaries**
  - Full: no request is issued.
  - Empty: `inst_valid` = 0; `inst`, `inst_pc` and `inst_npc` hold their last values.
  - Read and write pointers wrap modulo `DEPTH`.
- **Reset mid-operation**: immediate return to reset values; any response arriving during or after reset is ignored.

## Timing
- All outputs are registered, except `imem_req` and `imem_addr`, which are decoded from state, count, `fetch_pc` and `req_addr`.
- Reset release: `imem_req` = 1 in the first cycle after `rst` rises.
- Fetch latency, zero-wait memory: ack in cycle N gives `inst_valid` = 1 in cycle N+1.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and `id_ready` held at 1.
- Redirect in cycle N with no request pending:
  - `imem_addr` = `redirect_pc` in N+1.
  - First target instruction is valid in N+2.
- Redirect with a request pending: add the remaining ack wait of the stale request.
- `inst_valid` is 0 in the cycle after any redirect.

## Configuration
- Macro `FETCH_STATS_EN`.
- When defined, two outputs are added:
  - `stat_fetch_cnt` (16 bits): counts accepted pushes.
  - `stat_discard_cnt` (16 bits): counts dropped responses.
  - Both saturate at 16'hFFFF and clear on reset.
- When not defined, the ports and counters are absent; all other behaviour is identical.

## Structure
- `ISIZE` and `DSIZE` come from `define.v`.
- Also place in the shared header: the FETCH/DISCARD state encodings, the `RESET_PC` default, and the `DEPTH` bounds.
- Sub-module `fetch_queue`:
  - `DEPTH`-entry FIFO holding {inst, pc}.
  - Ports: push, pop, flush, full, empty, count, head outputs.
  - Flush has priority over push and pop.

## Test plan
- Reset release, zero-wait memory, `id_ready` = 1:
  - Addresses 0,1,2,3 are issued on consecutive cycles.
  - `inst_pc` = 0,1,2,3 starting one cycle after the first ack.
  - `inst_npc` = `inst_pc` + 1.
- `id_ready` = 0, `DEPTH` = 2:
  - After two acks, `imem_req` = 0 and `inst_valid` stays 1.
  - Raising `id_ready` restarts fetch at address 2.
- Redirect to 16'h0040 while a request to 16'h0005 waits for ack (ack arrives 3 cycles later):
  - `imem_addr` stays at 5 until the ack.
  - The data returned for 5 is dropped.
  - The next request is to 0x40, and no instruction with pc 5 appears.
- Redirect to 0x10 in the same cycle as an ack and a pop:
  - The queue empties and the returned word is dropped.
  - The next `imem_addr` is 0x10.
- `RESET_PC` = 16'hFFFE:
  - Fetch order is FFFE, FFFF, 0000.
  - `inst_npc` for FFFF is 0000.
- `rst` asserted while in DISCARD:
  - All outputs return to reset values at once.
  - An ack during reset has no effect.
  - With `FETCH_STATS_EN` defined, both counters read 0.
